// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: ALU, LSB and Branch results share one registered
// broadcast port, picked round-robin from one-entry holding registers.
module cdb_arbiter #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clear,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsb_valid,
    output logic              lsb_ready,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_data,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic [DATA_W-1:0] br_data,
    input  logic              br_jump,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              cdb_valid,
    output logic [1:0]        cdb_src,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_jump,
    output logic [ADDR_W-1:0] cdb_pc
);

    logic [2:0]              pend;
    logic [2:0][TAG_W-1:0]   tag_q;
    logic [2:0][DATA_W-1:0]  data_q;
    logic                    jump_q;
    logic [ADDR_W-1:0]       pc_q;
    logic [1:0]              rr_ptr;

    logic [2:0]              valid_in;
    logic [2:0]              ready;
    logic [2:0][TAG_W-1:0]   tag_in;
    logic [2:0][DATA_W-1:0]  data_in;
    logic [1:0]              ptr;
    logic [1:0]              o1;
    logic [1:0]              o2;
    logic [1:0]              win;
    logic                    any;
    logic [2:0]              grant;
    logic [1:0]              rr_next;

    assign valid_in = {br_valid, lsb_valid, alu_valid};
    assign tag_in   = {br_tag, lsb_tag, alu_tag};
    assign data_in  = {br_data, lsb_data, alu_data};

    // An illegal pointer value of 3 is folded back onto the ALU.
    always_comb begin
        ptr = (rr_ptr == 2'd3) ? 2'd0 : rr_ptr;
        o1  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        o2  = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        any = |pend;
        if (pend[ptr])
            win = ptr;
        else if (pend[o1])
            win = o1;
        else if (pend[o2])
            win = o2;
        else
            win = 2'd0;
        grant   = any ? (3'b001 << win) : 3'b000;
        rr_next = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end

    // A granted entry frees its slot in the same cycle it is broadcast.
    assign ready = {3{rdy & ~clear & rst_n}} & (~pend | grant);
    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];
    assign br_ready  = ready[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            jump_q    <= 1'b0;
            pc_q      <= '0;
            rr_ptr    <= 2'd0;
            cdb_valid <= 1'b0;
            cdb_src   <= 2'd0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_jump  <= 1'b0;
            cdb_pc    <= '0;
        end else if (rdy) begin
            if (clear) begin
                pend      <= '0;
                cdb_valid <= 1'b0;
            end else begin
                if (any) begin
                    cdb_valid <= 1'b1;
                    cdb_src   <= win;
                    cdb_tag   <= tag_q[win];
                    cdb_data  <= data_q[win];
                    cdb_jump  <= (win == 2'd2) & jump_q;
                    cdb_pc    <= (win == 2'd2) ? pc_q : '0;
                    rr_ptr    <= rr_next;
                end else begin
                    cdb_valid <= 1'b0;
                end
                pend <= (pend & ~grant) | (valid_in & ready);
            end
            for (int i = 0; i < 3; i++) begin
                if (valid_in[i] & ready[i]) begin
                    tag_q[i]  <= tag_in[i];
                    data_q[i] <= data_in[i];
                end
            end
            if (br_valid & ready[2]) begin
                jump_q <= br_jump;
                pc_q   <= br_pc;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed cases with literal expectations plus
// random traffic checked each cycle against a slot/pointer reference model.
module tb_cdb_arbiter;

    localparam int TW = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rdy = 1'b1;
    logic          clear = 1'b0;
    logic          iv [3];
    logic [TW-1:0] itag [3];
    logic [DW-1:0] idata [3];
    logic          ijump = 1'b0;
    logic [AW-1:0] ipc = '0;

    logic          alu_ready, lsb_ready, br_ready;
    logic          cdb_valid, cdb_jump;
    logic [1:0]    cdb_src;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic [AW-1:0] cdb_pc;

    cdb_arbiter #(.TAG_W(TW), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .alu_valid(iv[0]), .alu_ready(alu_ready),
        .alu_tag(itag[0]), .alu_data(idata[0]),
        .lsb_valid(iv[1]), .lsb_ready(lsb_ready),
        .lsb_tag(itag[1]), .lsb_data(idata[1]),
        .br_valid(iv[2]), .br_ready(br_ready),
        .br_tag(itag[2]), .br_data(idata[2]),
        .br_jump(ijump), .br_pc(ipc),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_jump(cdb_jump), .cdb_pc(cdb_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: one slot per source plus a round-robin start index.
    bit            m_pend [3];
    logic [TW-1:0] m_tag [3];
    logic [DW-1:0] m_data [3];
    logic          m_jump;
    logic [AW-1:0] m_pc;
    int            m_rr;
    logic          e_valid, e_jump;
    logic [1:0]    e_src;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_pc;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 0;
            m_tag[i]  = '0;
            m_data[i] = '0;
        end
        m_jump = 0; m_pc = '0; m_rr = 0;
        e_valid = 0; e_jump = 0; e_src = 0;
        e_tag = '0; e_data = '0; e_pc = '0;
    endtask

    task automatic idle_in();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 0; itag[i] = '0; idata[i] = '0;
        end
        ijump = 0; ipc = '0; clear = 0; rdy = 1;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic step();
        int win;
        bit er [3];
        #1;
        win = -1;
        for (int i = 0; i < 3; i++) begin
            int s;
            s = (m_rr + i) % 3;
            if (m_pend[s] && win < 0) win = s;
        end
        for (int x = 0; x < 3; x++)
            er[x] = rdy && !clear && (!m_pend[x] || win == x);
        chk("alu_ready", alu_ready, er[0]);
        chk("lsb_ready", lsb_ready, er[1]);
        chk("br_ready", br_ready, er[2]);
        @(posedge clk);
        if (rdy) begin
            if (clear) begin
                for (int i = 0; i < 3; i++) m_pend[i] = 0;
                e_valid = 0;
            end else begin
                if (win >= 0) begin
                    e_valid = 1;
                    e_src = 2'(win);
                    e_tag = m_tag[win];
                    e_data = m_data[win];
                    e_jump = (win == 2) ? m_jump : 1'b0;
                    e_pc = (win == 2) ? m_pc : '0;
                    m_pend[win] = 0;
                    m_rr = (win + 1) % 3;
                end else begin
                    e_valid = 0;
                end
                for (int x = 0; x < 3; x++) begin
                    if (iv[x] && er[x]) begin
                        m_pend[x] = 1;
                        m_tag[x] = itag[x];
                        m_data[x] = idata[x];
                        if (x == 2) begin
                            m_jump = ijump;
                            m_pc = ipc;
                        end
                    end
                end
            end
        end
        #1;
        chk("cdb_valid", cdb_valid, e_valid);
        chk("cdb_src", cdb_src, e_src);
        chk("cdb_tag", cdb_tag, e_tag);
        chk("cdb_data", cdb_data, e_data);
        chk("cdb_jump", cdb_jump, e_jump);
        chk("cdb_pc", cdb_pc, e_pc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_valid", cdb_valid, 0);
        chk("rst_src", cdb_src, 0);
        chk("rst_tag", cdb_tag, 0);
        chk("rst_data", cdb_data, 0);
        chk("rst_jump", cdb_jump, 0);
        chk("rst_pc", cdb_pc, 0);
        chk("rst_rdy", {alu_ready, lsb_ready, br_ready}, 0);
        model_reset();
        @(negedge clk);
        idle_in();
        rst_n = 1;
    endtask

    initial begin
        idle_in();
        model_reset();
        do_reset();

        // single ALU result
        iv[0] = 1; itag[0] = 4'd3; idata[0] = 32'h11;
        step();
        iv[0] = 0;
        #1 chk("t1_alu_ready", alu_ready, 1);
        step();
        chk("t1_valid", cdb_valid, 1);
        chk("t1_src", cdb_src, 0);
        chk("t1_tag", cdb_tag, 3);
        chk("t1_data", cdb_data, 32'h11);
        step();

        // all three at once from a fresh pointer
        do_reset();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1; itag[i] = 4'(i + 1); idata[i] = 32'(i + 100);
        end
        step();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_valid", cdb_valid, 1);
            chk("t2_src", cdb_src, k);
            chk("t2_tag", cdb_tag, k + 1);
        end
        chk("t2_rr", m_rr, 0);
        step();

        // ALU streaming against one LSB entry
        do_reset();
        iv[1] = 1; itag[1] = 4'd9; idata[1] = 32'h99;
        for (int c = 0; c < 8; c++) begin
            iv[0] = 1; itag[0] = 4'(c); idata[0] = 32'(c + 32'h200);
            step();
            iv[1] = 0;
        end
        idle_in();
        repeat (3) step();

        // branch with redirect, then an ALU broadcast
        do_reset();
        iv[2] = 1; itag[2] = 4'd5; idata[2] = 32'h24;
        ijump = 1; ipc = 32'h1000;
        step();
        idle_in();
        iv[0] = 1; itag[0] = 4'd7; idata[0] = 32'h77;
        step();
        idle_in();
        chk("t4_src", cdb_src, 2);
        chk("t4_jump", cdb_jump, 1);
        chk("t4_pc", cdb_pc, 32'h1000);
        chk("t4_data", cdb_data, 32'h24);
        step();
        chk("t4b_src", cdb_src, 0);
        chk("t4b_jump", cdb_jump, 0);
        chk("t4b_pc", cdb_pc, 0);

        // clear with pending entries and a fresh offer
        iv[0] = 1; iv[1] = 1; itag[0] = 4'd1; itag[1] = 4'd2;
        step();
        iv[0] = 0; iv[1] = 1; itag[1] = 4'd6; clear = 1;
        step();
        chk("t5_valid", cdb_valid, 0);
        idle_in();
        #1 chk("t5_rdy", {alu_ready, lsb_ready, br_ready}, 3'b111);
        step();
        chk("t5_quiet", cdb_valid, 0);

        // freeze with rdy low, then async reset mid-stream
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1; itag[i] = 4'(i + 10);
        end
        step();
        rdy = 0; clear = 1;
        repeat (3) step();
        chk("t6_pend", m_pend[0] + m_pend[1] + m_pend[2], 3);
        idle_in();
        step();
        do_reset();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i] = 1'($urandom_range(0, 1));
                itag[i] = 4'($urandom);
                idata[i] = $urandom;
            end
            ijump = 1'($urandom_range(0, 1));
            ipc = $urandom;
            rdy = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 24) == 0);
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle_in();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
